// File: rtl/fp8_mul_arbiter.sv
// Round-robin share of one external 4x4 multiplier; product registered 1 cycle after grant.
// Backpressure: a held, undrained response blocks all grants and freezes rsp_* and priority.
module fp8_mul_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [3:0]          mul_a,
    output logic [3:0]          mul_b,
    input  logic [7:0]          mul_product,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_product,
    output logic [CNTW-1:0]     ops_cnt
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] rr_ptr_nxt;
    logic           can_issue;
    logic           issue;

    assign can_issue = !rsp_valid || rsp_ready;
    assign issue     = can_issue && (|req_valid);

    // Circular priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        grant_idx = rr_ptr;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                grant_idx = IDW'(idx);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        if (grant_idx == IDW'(NREQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = grant_idx + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (issue && !rst) begin
            req_ready = NREQ'(1) << grant_idx;
        end
        if (issue) begin
            mul_a = req_a[4*grant_idx +: 4];
            mul_b = req_b[4*grant_idx +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            ops_cnt     <= '0;
            rr_ptr      <= '0;
        end else if (issue) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= grant_idx;
            rsp_product <= mul_product;
            ops_cnt     <= ops_cnt + 1'b1;
            rr_ptr      <= rr_ptr_nxt;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Directed bench with a response scoreboard; the external multiplier is modelled behaviourally.
module tb_fp8_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_product;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic [15:0] ops_cnt;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

    fp8_mul_arbiter #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product),
        .ops_cnt(ops_cnt)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int prod);
        exp_t e;
        e.id   = 2'(id);
        e.prod = 8'(prod);
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int idx, input int a, input int b);
        req_a[4*idx +: 4] = 4'(a);
        req_b[4*idx +: 4] = 4'(b);
    endtask

    // Monitor: every handshaken response must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", int'(rsp_id), int'(e.id));
                chk("rsp_product", int'(rsp_product), int'(e.prod));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_id  [3];
        int b_a   [3];
        int b_b   [3];
        int b_p   [3];
        int t2_p  [4];

        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_product", int'(rsp_product), 0);
        chk("reset_ops_cnt", int'(ops_cnt), 0);
        req_valid = '0;
        rst = 1'b0;
        step();

        // 1: single request
        req_valid = 4'b0001;
        set_op(0, 3, 5);
        #1;
        chk("t1_req_ready", int'(req_ready), 4'b0001);
        chk("t1_mul_a", int'(mul_a), 3);
        chk("t1_mul_b", int'(mul_b), 5);
        push(0, 15);
        step();
        req_valid = '0;
        #1;
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        chk("t1_ops_cnt", int'(ops_cnt), 1);
        step();
        chk("t1_drained", int'(rsp_valid), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // 2: all four valid, grants 0..3 back-to-back
        t2_p = '{2, 12, 30, 56};
        set_op(0, 1, 2);
        set_op(1, 3, 4);
        set_op(2, 5, 6);
        set_op(3, 7, 8);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_req_ready", int'(req_ready), 1 << k);
            push(k, t2_p[k]);
            step();
            req_valid[k] = 1'b0;
        end
        #1;
        chk("t2_ops_cnt", int'(ops_cnt), 4);
        step();

        // 3: backpressure holds response and blocks grants
        req_valid = 4'b0001;
        set_op(0, 2, 7);
        #1;
        chk("t3_first_grant", int'(req_ready), 4'b0001);
        push(0, 14);
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 6, 9);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_bp_req_ready", int'(req_ready), 0);
            chk("t3_bp_mul_a", int'(mul_a), 0);
            chk("t3_bp_rsp_valid", int'(rsp_valid), 1);
            chk("t3_bp_rsp_id", int'(rsp_id), 0);
            chk("t3_bp_rsp_product", int'(rsp_product), 14);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_release_grant", int'(req_ready), 4'b0010);
        push(1, 54);
        step();
        req_valid = '0;
        #1;
        chk("t3_rsp_id", int'(rsp_id), 1);
        chk("t3_ops_cnt", int'(ops_cnt), 6);

        // 4: operand boundaries
        b_id = '{1, 2, 3};
        b_a  = '{15, 0, 1};
        b_b  = '{15, 9, 15};
        b_p  = '{225, 0, 15};
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'(1 << b_id[k]);
            set_op(b_id[k], b_a[k], b_b[k]);
            #1;
            chk("t4_req_ready", int'(req_ready), 1 << b_id[k]);
            push(b_id[k], b_p[k]);
            step();
        end
        req_valid = '0;

        // 5: fairness between requesters 0 and 2
        set_op(0, 4, 4);
        set_op(2, 9, 3);
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("t5_grant", int'(req_ready), 4'b0001);
                push(0, 16);
            end else begin
                chk("t5_grant", int'(req_ready), 4'b0100);
                push(2, 27);
            end
            step();
        end
        req_valid = '0;
        #1;
        chk("t5_ops_cnt", int'(ops_cnt), 15);

        // 6: reset while a response is held and priority sits at 2
        req_valid = 4'b0010;
        set_op(1, 2, 2);
        #1;
        chk("t6_pre_grant", int'(req_ready), 4'b0010);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("t6_held_valid", int'(rsp_valid), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rsp_valid", int'(rsp_valid), 0);
        chk("t6_rst_ops_cnt", int'(ops_cnt), 0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        set_op(1, 3, 3);
        set_op(3, 5, 5);
        #1;
        chk("t6_first_grant", int'(req_ready), 4'b0010);
        push(1, 9);
        step();
        req_valid = 4'b1000;
        #1;
        chk("t6_second_grant", int'(req_ready), 4'b1000);
        push(3, 25);
        step();
        req_valid = '0;
        step();
        step();
        chk("t6_ops_cnt", int'(ops_cnt), 2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
